updown_count_decoder: RTL
=========================

Name: updown_count_decoder

Overview:
- Receiver-side companion to the team's up/down counter: samples a counter's output bus and recovers direction, step events, wrap-arounds and protocol errors.
- Placed downstream of any up/down counter instance, in the same clock domain. Sampling is qualified by a valid strobe.
- Feeds status logic and self-checking benches.
- All outputs are registered.

Parameters:
- BITS, 4, width of the observed count bus. Values are unsigned, modulo 2^BITS.
- WRAPW, 8, width of the saturating wrap-event counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_count is sampled this cycle.
- in_count  input  BITS  observed counter value.
- locked  output  1  a reference sample is held and the last step was legal.
- dir  output  1  1 = counting up, 0 = counting down. Meaningful only while locked.
- step_pulse  output  1  one-cycle pulse per legal ±1 step.
- wrap_pulse  output  1  one-cycle pulse on a wrap: max→0 up, or 0→max down.
- dir_change  output  1  one-cycle pulse when a legal step reverses the locked direction.
- step_err  output  1  one-cycle pulse on an illegal jump (delta not in {0, +1, −1}).
- wrap_cnt  output  WRAPW  saturating count of wrap events.

Behaviour:
- Reset (reset=0, asynchronous):
  - State EMPTY; prev = 0.
  - locked=0, dir=1, all pulses 0, wrap_cnt=0.
  - Reset asserted mid-operation discards the held sample immediately.
- States:
  - EMPTY: no reference sample held.
  - UP, DOWN: locked in that direction.
  - SYNC: reference held, direction unknown.
- Delta rule: delta = (in_count − prev) mod 2^BITS, computed in BITS bits. +1 means delta==1. −1 means delta==2^BITS−1. Zero means delta==0.
- Every in_valid sample updates prev <= in_count, including error samples.
- Cycles with in_valid=0 change nothing and drive all pulses to 0.
- Latency: pulses and state-derived outputs update on the clock edge that samples in_valid=1. They are visible the cycle after the input is presented.
- Transitions (in_valid=1):
  - EMPTY → SYNC. No pulses.
  - SYNC, +1 → UP. step_pulse.
  - SYNC, −1 → DOWN. step_pulse.
  - SYNC, 0 → stays in SYNC.
  - SYNC, other → stays in SYNC. step_err.
  - UP, +1 → UP. step_pulse.
  - UP, −1 → DOWN. step_pulse and dir_change.
  - DOWN, −1 → DOWN. step_pulse.
  - DOWN, +1 → UP. step_pulse and dir_change.
  - UP or DOWN, 0 → no change, no pulse (stalled counter).
  - UP or DOWN, other → SYNC. step_err; locked drops to 0.
- Wraps:
  - Legal +1 with prev==2^BITS−1 and in_count==0: wrap_pulse.
  - Legal −1 with prev==0 and in_count==2^BITS−1: wrap_pulse.
  - wrap_pulse coincides with step_pulse and, if applicable, dir_change.
  - wrap_cnt increments on each wrap_pulse and saturates at 2^WRAPW−1.
- locked = state ∈ {UP, DOWN}. dir = 1 in UP, 0 in DOWN; dir holds its last value in SYNC or EMPTY.
- A counter reset-to-max observed mid-stream is an illegal jump unless it is ±1. The decoder reports step_err and resyncs; it never infers counter reset.
- BITS=1 is degenerate: +1 and −1 are equal. Such a step resolves as +1 (up).

Optional Feature:
- Macro: UPDOWN_DECODER_POS_EN.
- When defined, an extra output `pos`, signed BITS+WRAPW bits, is added.
  - Reset value 0.
  - Adds +1 on each legal up step and −1 on each legal down step.
  - Reloads to in_count, zero-extended, on the EMPTY→SYNC sample.
  - Holds on step_err and on zero-delta samples.
  - Wraps in two's complement at its own width.
- When undefined, the port and the accumulator are absent. All other behaviour is identical.

Decomposition:
- Package updown_pkg holds:
  - state enum typedef (EMPTY, SYNC, UP, DOWN), 2 bits;
  - localparam function max_count(BITS) = 2^BITS−1;
  - delta-class enum (ZERO, INC, DEC, ILLEGAL).
- One natural sub-module, updown_delta_classify: combinational; takes prev and in_count, returns delta class and wrap flag. It is reused by benches as the reference model.

Test Plan (BITS=4, WRAPW=8):
- Reset, then valid samples 15,0,1 → first sample: locked=0. Second sample: step_pulse=1, wrap_pulse=1, locked=1, dir=1, wrap_cnt=1. Third sample: step_pulse only.
- Samples 5,4,3,4 → dir=0 after the 2nd sample. The 4th sample gives dir_change=1, dir=1. No wraps.
- Locked UP at 7, then sample 12 → step_err=1, locked=0. Next sample 13 → re-locks UP with step_pulse and no error.
- Locked DOWN at 0, sample 15 with in_valid gaps of 3 idle cycles before it → no pulses during the gaps. On the sample: wrap_pulse=1, dir stays 0.
- 300 consecutive up-wraps → wrap_cnt saturates at 255 and never rolls over.
- Reset asserted mid-stream between samples 9 and 10 → all outputs return to reset values asynchronously. Sample 10 after release yields no step_pulse (EMPTY→SYNC). With UPDOWN_DECODER_POS_EN defined, pos reloads to 10.

Source files
------------

// File: rtl/updown_pkg.sv
// updown_pkg: shared state/delta-class types and helpers for the up/down count decoder
package updown_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, SYNC = 2'd1, UP = 2'd2, DOWN = 2'd3} state_t;
    typedef enum logic [1:0] {ZERO = 2'd0, INC = 2'd1, DEC = 2'd2, ILLEGAL = 2'd3} delta_t;
    function automatic int unsigned max_count(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction
endpackage

// File: rtl/updown_delta_classify.sv
// updown_delta_classify: classifies a modular sample-to-sample delta and flags wraps
module updown_delta_classify
    import updown_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] prev_i,
    input  logic [BITS-1:0] count_i,
    output delta_t          cls_o,
    output logic            wrap_o
);
    localparam logic [BITS-1:0] MAX = BITS'(max_count(BITS));
    logic [BITS-1:0] delta;
    // INC is tested before DEC so a 1-bit bus resolves the ambiguous step as up
    always_comb begin
        delta  = count_i - prev_i;
        cls_o  = delta == '0 ? ZERO : delta == BITS'(1) ? INC : delta == MAX ? DEC : ILLEGAL;
        wrap_o = (cls_o == INC && prev_i == MAX && count_i == '0) ||
                 (cls_o == DEC && prev_i == '0 && count_i == MAX);
    end
endmodule

// File: rtl/updown_count_decoder.sv
// updown_count_decoder: recovers direction/steps/wraps/errors from a sampled up/down count (optional pos via UPDOWN_DECODER_POS_EN)
module updown_count_decoder
    import updown_pkg::*;
#(
    parameter int BITS  = 4,
    parameter int WRAPW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [BITS-1:0]  in_count,
    output logic             locked,
    output logic             dir,
    output logic             step_pulse,
    output logic             wrap_pulse,
    output logic             dir_change,
    output logic             step_err,
    output logic [WRAPW-1:0] wrap_cnt
`ifdef UPDOWN_DECODER_POS_EN
    ,
    output logic signed [BITS+WRAPW-1:0] pos
`endif
);
    localparam int PW = BITS + WRAPW;
    state_t           state_q, state_d;
    logic [BITS-1:0]  prev_q, prev_d;
    logic             dir_q, dir_d, locked_q, locked_d;
    logic             step_q, step_d, wrap_q, wrap_d, chg_q, chg_d, err_q, err_d;
    logic [WRAPW-1:0] wcnt_q, wcnt_d;
    delta_t           cls;
    logic             wrap, legal, held;
    updown_delta_classify #(.BITS(BITS)) u_cls (
        .prev_i  (prev_q),
        .count_i (in_count),
        .cls_o   (cls),
        .wrap_o  (wrap)
    );
    always_comb begin
        held     = in_valid && state_q != EMPTY;
        legal    = held && (cls == INC || cls == DEC);
        state_d  = !in_valid ? state_q : state_q == EMPTY ? SYNC : cls == ILLEGAL ? SYNC :
                   cls == INC ? UP : cls == DEC ? DOWN : state_q;
        prev_d   = in_valid ? in_count : prev_q;
        step_d   = legal;
        wrap_d   = legal && wrap;
        chg_d    = legal && ((state_q == UP && cls == DEC) || (state_q == DOWN && cls == INC));
        err_d    = held && cls == ILLEGAL;
        dir_d    = legal ? cls == INC : dir_q;
        locked_d = state_d == UP || state_d == DOWN;
        wcnt_d   = wrap_d && wcnt_q != '1 ? wcnt_q + WRAPW'(1) : wcnt_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            prev_q   <= '0;
            dir_q    <= 1'b1;
            locked_q <= 1'b0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
            chg_q    <= 1'b0;
            err_q    <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
            chg_q    <= chg_d;
            err_q    <= err_d;
            wcnt_q   <= wcnt_d;
        end
    end
    assign locked     = locked_q;
    assign dir        = dir_q;
    assign step_pulse = step_q;
    assign wrap_pulse = wrap_q;
    assign dir_change = chg_q;
    assign step_err   = err_q;
    assign wrap_cnt   = wcnt_q;
`ifdef UPDOWN_DECODER_POS_EN
    logic signed [PW-1:0] pos_q, pos_d;
    always_comb begin
        pos_d = !in_valid ? pos_q : state_q == EMPTY ? PW'(in_count) :
                !legal ? pos_q : cls == INC ? pos_q + PW'(1) : pos_q - PW'(1);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pos_q <= '0;
        else        pos_q <= pos_d;
    end
    assign pos = pos_q;
`endif
endmodule
